// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl
//   Simulation run controller placed between the top-level clock/reset source
//   and the DUT. After rst_i drops it releases NumDomains reset domains one at
//   a time, ResetStagger edges apart, and then enters RUN. In RUN it watches
//   for a halt request, a cycle budget and a heartbeat watchdog. Whichever
//   fires first moves the controller into FINISH, which is terminal until
//   rst_i. In FINISH the sticky finish flag, status and exit code are held.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   heartbeat_i    DUT progress pulse, sampled in RUN only
//   halt_i         DUT end-of-test request, sampled in RUN only
//   halt_code_i    DUT exit code, valid with halt_i
//   rst_domain_o   per-domain reset, active-high
//   run_o          high while in RUN
//   finish_o       sticky end-of-simulation flag
//   status_o       0 NONE, 1 PASS, 2 FAIL, 3 TIMEOUT
//   exit_code_o    captured exit code
//   cycle_count_o  edges since rst_i deassertion, saturating
//
// Every output is a register. No input reaches an output combinationally.
module sim_run_ctrl #(
  parameter int NumDomains     = 4,
  parameter int ResetStagger   = 2,
  parameter int MaxCycles      = 16384,
  parameter int WatchdogCycles = 1024,
  parameter int CountWidth     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  heartbeat_i,
  input  logic                  halt_i,
  input  logic [7:0]            halt_code_i,
  output logic [NumDomains-1:0] rst_domain_o,
  output logic                  run_o,
  output logic                  finish_o,
  output logic [1:0]            status_o,
  output logic [7:0]            exit_code_o,
  output logic [CountWidth-1:0] cycle_count_o
);

  localparam int ReleaseEdges = NumDomains * ResetStagger;
  localparam int StaggerWidth = $clog2(ReleaseEdges + 1);

  localparam logic [StaggerWidth-1:0] ReleaseDone = StaggerWidth'(ReleaseEdges);
  localparam logic [CountWidth-1:0]   CountMax    = '1;
  localparam logic [CountWidth-1:0]   BudgetLimit = CountWidth'(MaxCycles);
  // When the watchdog is disabled, this value is never compared (see wd_hit).
  localparam logic [CountWidth-1:0]   WdLast      = CountWidth'(WatchdogCycles - 1);

  localparam logic [1:0] StatusNone    = 2'd0;
  localparam logic [1:0] StatusPass    = 2'd1;
  localparam logic [1:0] StatusFail    = 2'd2;
  localparam logic [1:0] StatusTimeout = 2'd3;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_RELEASE,
    ST_RUN,
    ST_FINISH
  } state_t;

  state_t                  state_reg;
  logic [StaggerWidth-1:0] stagger_reg;
  logic [CountWidth-1:0]   wd_reg;

  logic [StaggerWidth-1:0] stagger_next;
  logic [CountWidth-1:0]   count_next;
  logic [NumDomains-1:0]   dom_hold_next;
  logic                    budget_hit;
  logic                    wd_hit;
  logic                    fin_req;
  logic [1:0]              fin_status;
  logic [7:0]              fin_code;

  // stagger_reg counts edges since deassertion while releasing. It leaves
  // RELEASE at ReleaseDone, so it cannot overflow.
  assign stagger_next = stagger_reg + StaggerWidth'(1);
  assign count_next   = (cycle_count_o == CountMax) ? cycle_count_o
                                                    : cycle_count_o + CountWidth'(1);
  // The budget is compared against the value that this edge writes. The
  // timeout edge therefore shows cycle_count_o == MaxCycles.
  assign budget_hit   = (count_next == BudgetLimit);
  assign wd_hit       = (WatchdogCycles != 0) && !heartbeat_i && (wd_reg == WdLast);

  // Domain gi stays in reset until edge ResetStagger*(gi+1).
  for (genvar gi = 0; gi < NumDomains; gi++) begin : g_dom
    assign dom_hold_next[gi] = (stagger_next < StaggerWidth'(ResetStagger * (gi + 1)));
  end

  // Finish request, in priority order: halt, then budget, then watchdog.
  always_comb begin
    fin_req    = 1'b0;
    fin_status = StatusNone;
    fin_code   = 8'h00;
    case (state_reg)
      ST_RESET, ST_RELEASE: begin
        if (budget_hit) begin
          fin_req    = 1'b1;
          fin_status = StatusTimeout;
          fin_code   = 8'hFF;
        end
      end
      ST_RUN: begin
        if (halt_i) begin
          fin_req    = 1'b1;
          fin_status = (halt_code_i == 8'h00) ? StatusPass : StatusFail;
          fin_code   = halt_code_i;
        end else if (budget_hit) begin
          fin_req    = 1'b1;
          fin_status = StatusTimeout;
          fin_code   = 8'hFF;
        end else if (wd_hit) begin
          fin_req    = 1'b1;
          fin_status = StatusTimeout;
          fin_code   = 8'hFE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_RESET;
      rst_domain_o  <= '1;
      run_o         <= 1'b0;
      finish_o      <= 1'b0;
      status_o      <= StatusNone;
      exit_code_o   <= 8'h00;
      cycle_count_o <= '0;
      wd_reg        <= '0;
      stagger_reg   <= '0;
    end else begin
      case (state_reg)
        ST_RESET, ST_RELEASE: begin
          cycle_count_o <= count_next;
          stagger_reg   <= stagger_next;
          if (fin_req) begin
            state_reg    <= ST_FINISH;
            finish_o     <= 1'b1;
            run_o        <= 1'b0;
            rst_domain_o <= '1;
            status_o     <= fin_status;
            exit_code_o  <= fin_code;
          end else begin
            rst_domain_o <= dom_hold_next;
            if (stagger_next == ReleaseDone) begin
              state_reg <= ST_RUN;
              run_o     <= 1'b1;
              wd_reg    <= '0;
            end else begin
              state_reg <= ST_RELEASE;
            end
          end
        end
        ST_RUN: begin
          cycle_count_o <= count_next;
          wd_reg        <= heartbeat_i ? '0
                         : ((wd_reg == CountMax) ? wd_reg : wd_reg + CountWidth'(1));
          if (fin_req) begin
            state_reg    <= ST_FINISH;
            finish_o     <= 1'b1;
            run_o        <= 1'b0;
            rst_domain_o <= '1;
            status_o     <= fin_status;
            exit_code_o  <= fin_code;
          end
        end
        ST_FINISH: begin
          // Terminal. The DUT is held in reset and every result is frozen.
          rst_domain_o <= '1;
          run_o        <= 1'b0;
          finish_o     <= 1'b1;
        end
        default: state_reg <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl
//   Bench for sim_run_ctrl. Two instances share the same input stimulus:
//     dut_a: 4 domains, stagger 2, budget 200, watchdog 16, 32-bit counter
//     dut_b: 3 domains, stagger 3, budget 120, watchdog off, 16-bit counter
//   The stimulus is a series of episodes. Each episode has some reset edges,
//   then a per-edge table of heartbeat/halt/code values. A reference model
//   derives each episode's outcome (finish edge, status, code) from the
//   controller's rules. It then pushes one expected output word per edge into a
//   queue for each instance. A separate monitor pops one word and compares it
//   with the DUT outputs at each falling edge.
module tb_sim_run_ctrl;

  typedef struct packed {
    logic [3:0]  dom;
    logic        run;
    logic        fin;
    logic [1:0]  st;
    logic [7:0]  cd;
    logic [31:0] cnt;
  } obs_t;

  logic        clk;
  logic        rst;
  logic        hb;
  logic        halt;
  logic [7:0]  code;

  logic [3:0]  dom_a;
  logic        run_a, fin_a;
  logic [1:0]  st_a;
  logic [7:0]  cd_a;
  logic [31:0] cnt_a;

  logic [2:0]  dom_b;
  logic        run_b, fin_b;
  logic [1:0]  st_b;
  logic [7:0]  cd_b;
  logic [15:0] cnt_b;

  int checks = 0;
  int errors = 0;

  obs_t exp_a_q[$];
  obs_t exp_b_q[$];
  int   tag_q[$];

  // Per-edge stimulus table for the current episode. Index n is edge n.
  logic       hb_v   [0:511];
  logic       halt_v [0:511];
  logic [7:0] code_v [0:511];

  sim_run_ctrl #(
    .NumDomains(4), .ResetStagger(2), .MaxCycles(200), .WatchdogCycles(16), .CountWidth(32)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .heartbeat_i(hb), .halt_i(halt), .halt_code_i(code),
    .rst_domain_o(dom_a), .run_o(run_a), .finish_o(fin_a), .status_o(st_a),
    .exit_code_o(cd_a), .cycle_count_o(cnt_a)
  );

  sim_run_ctrl #(
    .NumDomains(3), .ResetStagger(3), .MaxCycles(120), .WatchdogCycles(0), .CountWidth(16)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .heartbeat_i(hb), .halt_i(halt), .halt_code_i(code),
    .rst_domain_o(dom_b), .run_o(run_b), .finish_o(fin_b), .status_o(st_b),
    .exit_code_o(cd_b), .cycle_count_o(cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Episode outcome: the first edge at which the run ends, or 0 if it does
  // not end within len edges.
  task automatic model(input int nd, input int s, input int m, input int w, input int len,
                       output int f, output logic [1:0] st, output logic [7:0] cd);
    int rs;
    int last_clear;
    rs = nd * s;
    f  = 0;
    st = 2'd0;
    cd = 8'h00;
    if (m <= rs) begin
      if (m <= len) begin
        f  = m;
        st = 2'd3;
        cd = 8'hFF;
      end
      return;
    end
    last_clear = rs;
    for (int n = rs + 1; n <= len; n++) begin
      if (halt_v[n]) begin
        f  = n;
        st = (code_v[n] == 8'h00) ? 2'd1 : 2'd2;
        cd = code_v[n];
        return;
      end
      if (n == m) begin
        f  = n;
        st = 2'd3;
        cd = 8'hFF;
        return;
      end
      if (hb_v[n]) last_clear = n;
      else if (w != 0 && (n - last_clear) == w) begin
        f  = n;
        st = 2'd3;
        cd = 8'hFE;
        return;
      end
    end
  endtask

  function automatic obs_t reset_obs(input int nd);
    obs_t e;
    e     = '0;
    e.dom = 4'((1 << nd) - 1);
    return e;
  endfunction

  function automatic obs_t expect_at(input int n, input int nd, input int s, input int f,
                                     input logic [1:0] st, input logic [7:0] cd);
    obs_t e;
    e = '0;
    if (f != 0 && n >= f) begin
      e.dom = 4'((1 << nd) - 1);
      e.fin = 1'b1;
      e.st  = st;
      e.cd  = cd;
      e.cnt = 32'(f);
    end else begin
      for (int k = 0; k < nd; k++) e.dom[k] = (n < s * (k + 1));
      e.run = (n >= nd * s);
      e.cnt = 32'(n);
    end
    return e;
  endfunction

  task automatic clear_table();
    for (int i = 0; i < 512; i++) begin
      hb_v[i]   = 1'b0;
      halt_v[i] = 1'b0;
      code_v[i] = 8'h00;
    end
  endtask

  task automatic random_table(input int len);
    int hb_div;
    int halt_div;
    clear_table();
    case ($urandom_range(0, 3))
      0:       hb_div = 1;
      1:       hb_div = 4;
      2:       hb_div = 12;
      default: hb_div = 40;
    endcase
    halt_div = ($urandom_range(0, 2) == 0) ? 1000 : 90;
    for (int n = 1; n <= len; n++) begin
      hb_v[n]   = ($urandom_range(0, hb_div - 1) == 0);
      halt_v[n] = ($urandom_range(0, halt_div - 1) == 0);
      code_v[n] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
    end
  endtask

  task automatic run_episode(input int rlen, input int len);
    int         fa, fb;
    logic [1:0] sa, sb;
    logic [7:0] ca, cb;
    model(4, 2, 200, 16, len, fa, sa, ca);
    model(3, 3, 120, 0, len, fb, sb, cb);
    for (int r = 0; r < rlen; r++) begin
      rst  = 1'b1;
      hb   = 1'($urandom_range(0, 1));
      halt = 1'($urandom_range(0, 1));
      code = 8'($urandom_range(0, 255));
      exp_a_q.push_back(reset_obs(4));
      exp_b_q.push_back(reset_obs(3));
      tag_q.push_back(0);
      @(posedge clk);
      #1;
    end
    for (int n = 1; n <= len; n++) begin
      rst  = 1'b0;
      hb   = hb_v[n];
      halt = halt_v[n];
      code = code_v[n];
      exp_a_q.push_back(expect_at(n, 4, 2, fa, sa, ca));
      exp_b_q.push_back(expect_at(n, 3, 3, fb, sb, cb));
      tag_q.push_back(n);
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: one expected word per instance per edge.
  always @(negedge clk) begin
    obs_t ea, eb, oa, ob;
    int   tag;
    if (exp_a_q.size() > 0 && exp_b_q.size() > 0 && tag_q.size() > 0) begin
      ea  = exp_a_q.pop_front();
      eb  = exp_b_q.pop_front();
      tag = tag_q.pop_front();
      oa  = '{dom: dom_a, run: run_a, fin: fin_a, st: st_a, cd: cd_a, cnt: cnt_a};
      ob  = '{dom: {1'b0, dom_b}, run: run_b, fin: fin_b, st: st_b, cd: cd_b,
              cnt: {16'h0000, cnt_b}};
      checks = checks + 1;
      if (oa !== ea) begin
        errors = errors + 1;
        $display("FAIL dut_a edge %0d: got dom=%b run=%b fin=%b st=%0d code=%h cnt=%0d, want dom=%b run=%b fin=%b st=%0d code=%h cnt=%0d",
                 tag, oa.dom, oa.run, oa.fin, oa.st, oa.cd, oa.cnt,
                 ea.dom, ea.run, ea.fin, ea.st, ea.cd, ea.cnt);
      end
      checks = checks + 1;
      if (ob !== eb) begin
        errors = errors + 1;
        $display("FAIL dut_b edge %0d: got dom=%b run=%b fin=%b st=%0d code=%h cnt=%0d, want dom=%b run=%b fin=%b st=%0d code=%h cnt=%0d",
                 tag, ob.dom[2:0], ob.run, ob.fin, ob.st, ob.cd, ob.cnt,
                 eb.dom[2:0], eb.run, eb.fin, eb.st, eb.cd, eb.cnt);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    hb   = 1'b0;
    halt = 1'b0;
    code = 8'h00;

    // Release sequence, then a passing halt at edge 50 with heartbeats.
    clear_table();
    for (int n = 1; n <= 70; n++) hb_v[n] = (n % 10 == 0);
    halt_v[50] = 1'b1;
    run_episode(3, 70);
    $display("episode pass-halt done");

    // Failing halt on the very edge the dut_a budget expires.
    clear_table();
    for (int n = 1; n <= 210; n++) hb_v[n] = (n % 10 == 0);
    halt_v[200] = 1'b1;
    code_v[200] = 8'h2A;
    run_episode(2, 210);
    $display("episode halt-vs-budget done");

    // No heartbeat at all: dut_a watchdog fires at edge 24, dut_b keeps running.
    clear_table();
    run_episode(2, 40);
    $display("episode watchdog done");

    // Heartbeat held high: budgets of 120 and 200, then the outputs stay stable.
    clear_table();
    for (int n = 1; n <= 225; n++) hb_v[n] = 1'b1;
    run_episode(1, 225);
    $display("episode budget done");

    // Mid-run reset, then the release sequence restarts.
    clear_table();
    for (int n = 1; n <= 60; n++) hb_v[n] = (n % 5 == 0);
    run_episode(3, 29);
    run_episode(4, 50);
    $display("episode mid-run reset done");

    for (int ep = 0; ep < 18; ep++) begin
      int len;
      int rlen;
      len  = $urandom_range(20, 260);
      rlen = $urandom_range(1, 4);
      random_table(len);
      run_episode(rlen, len);
      $display("random episode %0d: reset=%0d edges=%0d", ep, rlen, len);
    end

    rst = 1'b1;
    @(negedge clk);
    #1;
    checks = checks + 1;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d/%0d expectations left, want 0/0",
               exp_a_q.size(), exp_b_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
